coproc_control_unit: RTL and testbench
======================================

Name: coproc_control_unit

Overview:
Initiator/sequencer side of the matrix ALU interface. Accepts 16-bit host instructions, builds the 5x5 int8 operand matrices A and B and the scalar f element by element, and issues one ALU opcode per EXEC. Waits for ALU done, or times out, then captures C_flat and the overflow flag and serves result elements back to the host. Sits between the host PIO bridge and the matrix ALU.

Parameters:
N_ELEM, 25, elements per matrix (5x5)
ELEM_W, 8, element width; element k occupies bits [ELEM_W*k+ELEM_W-1 : ELEM_W*k] of every flat bus
SETTLE_CYCLES, 2, minimum cycles the opcode is held before done is sampled (>=1)
TIMEOUT_CYCLES, 16, maximum cycles in ISSUE before the operation is aborted (>SETTLE_CYCLES)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous reset, active-low
instr_valid  in  1  host instruction valid
instr_ready  out  1  high only in IDLE
instr  in  16  [2:0] cmd, [7:3] index or ALU opcode, [15:8] data
rd_valid  out  1  one-cycle pulse; rd_data is valid
rd_data  out  8  captured C element
busy  out  1  state != IDLE
op_done  out  1  one-cycle pulse on result capture
op_overflow  out  1  overflow latched at the last capture
op_error  out  1  sticky error flag
alu_A_flat  out  200  operand A register
alu_B_flat  out  200  operand B register
alu_f  out  8  scalar register
alu_opcode  out  3  ALU opcode; 000 = no operation
alu_C_flat  in  200  ALU result
alu_overflow  in  1  ALU overflow
alu_done  in  1  ALU done

Behaviour:
- Reset, asynchronous: state IDLE. A, B, f and C registers = 0. alu_opcode = 000. rd_valid, op_done, op_overflow, op_error = 0. rd_data = 0. Once released, instr_ready = 1.
- Handshake: an instruction is accepted when instr_valid & instr_ready. instr_valid outside IDLE is ignored. Acceptance of any instruction clears op_error; that instruction may set it again.
- Commands in IDLE:
  - 000 NOP: no effect.
  - 001 LOAD_A: element instr[7:3] of A = instr[15:8].
  - 010 LOAD_B: same, for B.
  - 011 LOAD_F: f = instr[15:8].
  - 100 EXEC: ALU opcode = instr[5:3].
  - 101 READ_C: element index = instr[7:3].
  - 110, 111 reserved: op_error = 1.
  - LOAD_A, LOAD_B, LOAD_F and READ_C complete in one cycle; state stays IDLE.
- Index rule: an index > N_ELEM-1 sets op_error = 1, writes nothing and gives no rd_valid.
- READ_C: rd_data = C register element, registered. rd_valid pulses on the cycle after acceptance. Reads return the captured C register, never live alu_C_flat.
- EXEC with opcode 000: op_error = 1; no ALU activity; state stays IDLE.
- EXEC state machine: IDLE -> ISSUE -> (CAPTURE | timeout) -> RELEASE -> IDLE.
  - ISSUE: alu_opcode = latched opcode; cycle counter starts at 0.
  - Once count >= SETTLE_CYCLES-1 and alu_done = 1: -> CAPTURE.
  - If count reaches TIMEOUT_CYCLES-1 with alu_done = 0: op_error = 1, go to RELEASE, C register unchanged.
  - CAPTURE, one cycle: op_done = 1. At the end of the cycle, C register <= alu_C_flat and op_overflow <= alu_overflow.
  - RELEASE, one cycle: alu_opcode = 000 so that the next EXEC presents an opcode change to the ALU. Then IDLE.
  - alu_opcode is 000 in every state except ISSUE and CAPTURE.
- Latency, EXEC accepted in cycle 0 with alu_done already high:
  - alu_opcode valid from cycle 1.
  - CAPTURE and op_done in cycle SETTLE_CYCLES+1.
  - RELEASE in cycle SETTLE_CYCLES+2.
  - instr_ready high in cycle SETTLE_CYCLES+3; with defaults, op_done in cycle 3 and ready in cycle 5.
- op_overflow holds until the next CAPTURE or reset. A timeout does not change it.
- Reset mid-operation: immediate return to reset values, including alu_opcode = 000. Partially loaded A and B are cleared.
- Operand registers are never modified by EXEC.

Decomposition:
- Package coproc_pkg:
  - Command encodings: CMD_NOP, CMD_LOAD_A, CMD_LOAD_B, CMD_LOAD_F, CMD_EXEC, CMD_READ_C.
  - ALU opcode constants: SUM=001, SUB=010, MUL=011, OPP=100, TRN=101, SCL=110, DET=111, NONE=000.
  - N_ELEM, ELEM_W.
  - State enum: IDLE, ISSUE, CAPTURE, RELEASE.
- Sub-module coproc_matrix_bank: 25x8 register bank with indexed byte write, indexed byte read, flat 200-bit output and synchronous clear. Instantiated for A and B.
- The C register is a plain 200-bit parallel-load register in the top level.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle -> all outputs 0 asynchronously; instr_ready = 1 after release; alu_opcode = 000.
- Sum path: LOAD_A idx0 = 3, LOAD_B idx0 = 4, EXEC 001; ALU model gives done = 1, C elem0 = 7 -> op_done in cycle 3, alu_opcode = 000 in cycle 4, ready in cycle 5; READ_C idx0 -> rd_valid with rd_data = 7 one cycle later.
- Timeout: EXEC 111 with ALU done held 0 -> op_error = 1 after 16 ISSUE cycles, no op_done, C unchanged, alu_opcode returns to 000.
- Bad index: LOAD_A idx 25 -> op_error = 1, A unchanged; NOP next -> op_error = 0. EXEC 000 -> op_error = 1, busy never asserts.
- Overflow: EXEC 011 with alu_overflow = 1 -> op_overflow = 1 after capture and held through READ_C; next EXEC with overflow 0 -> cleared.
- Mid-op reset and busy: instr_valid during ISSUE is ignored (instr_ready = 0); rst_n low during ISSUE -> busy = 0 and alu_opcode = 000 immediately.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared encodings and sizes for the matrix coprocessor control path.
package coproc_pkg;
    localparam int N_ELEM = 25;
    localparam int ELEM_W = 8;
    localparam int IDX_W  = 5;
    localparam int FLAT_W = N_ELEM * ELEM_W;

    localparam logic [2:0] CMD_NOP    = 3'b000;
    localparam logic [2:0] CMD_LOAD_A = 3'b001;
    localparam logic [2:0] CMD_LOAD_B = 3'b010;
    localparam logic [2:0] CMD_LOAD_F = 3'b011;
    localparam logic [2:0] CMD_EXEC   = 3'b100;
    localparam logic [2:0] CMD_READ_C = 3'b101;

    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] SUM  = 3'b001;
    localparam logic [2:0] SUB  = 3'b010;
    localparam logic [2:0] MUL  = 3'b011;
    localparam logic [2:0] OPP  = 3'b100;
    localparam logic [2:0] TRN  = 3'b101;
    localparam logic [2:0] SCL  = 3'b110;
    localparam logic [2:0] DET  = 3'b111;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RELEASE} state_t;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return int'(idx) < N_ELEM;
    endfunction
endpackage

// File: rtl/coproc_if.sv
// Bus between the control unit (master) and the matrix ALU (slave).
interface coproc_if;
    import coproc_pkg::*;

    logic [FLAT_W-1:0] alu_A_flat;
    logic [FLAT_W-1:0] alu_B_flat;
    logic [ELEM_W-1:0] alu_f;
    logic [2:0]        alu_opcode;
    logic [FLAT_W-1:0] alu_C_flat;
    logic              alu_overflow;
    logic              alu_done;

    modport master (
        output alu_A_flat, alu_B_flat, alu_f, alu_opcode,
        input  alu_C_flat, alu_overflow, alu_done
    );

    modport slave (
        input  alu_A_flat, alu_B_flat, alu_f, alu_opcode,
        output alu_C_flat, alu_overflow, alu_done
    );
endinterface

// File: rtl/coproc_matrix_bank.sv
// 25x8 operand register bank: indexed byte write, flat parallel output.
module coproc_matrix_bank
    import coproc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ELEM_W-1:0] wr_data,
    output logic [FLAT_W-1:0] flat
);
    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
            logic [ELEM_W-1:0] elem_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    elem_reg <= '0;
                end else if (clr) begin
                    elem_reg <= '0;
                end else if (wr_en && wr_idx == IDX_W'(gi)) begin
                    elem_reg <= wr_data;
                end
            end

            assign flat[ELEM_W*gi +: ELEM_W] = elem_reg;
        end
    endgenerate
endmodule

// File: rtl/coproc_control_unit.sv
// Host-instruction sequencer for the matrix ALU: operand loading, opcode
// issue with settle/timeout handling, result capture and read-back.
module coproc_control_unit
    import coproc_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic              rd_valid,
    output logic [ELEM_W-1:0] rd_data,
    output logic              busy,
    output logic              op_done,
    output logic              op_overflow,
    output logic              op_error,
    coproc_if.master          alu
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [2:0]        opcode_reg;
    logic [ELEM_W-1:0] f_reg;
    logic [ELEM_W-1:0] rd_data_reg;
    logic [FLAT_W-1:0] c_reg;
    logic              rd_valid_reg;
    logic              overflow_reg;
    logic              error_reg, error_next;

    logic [2:0]        cmd;
    logic [IDX_W-1:0]  idx;
    logic [ELEM_W-1:0] data;
    logic [2:0]        exec_op;
    logic              accept, idx_ok, wr_a, wr_b, rd_c, start_exec;
    logic              settled, expired, capture_go, timeout;
    logic [FLAT_W-1:0] a_flat, b_flat;

    assign cmd     = instr[2:0];
    assign idx     = instr[7:3];
    assign data    = instr[15:8];
    assign exec_op = instr[5:3];

    assign accept     = instr_valid && (state_reg == IDLE);
    assign idx_ok     = idx_in_range(idx);
    assign wr_a       = accept && (cmd == CMD_LOAD_A) && idx_ok;
    assign wr_b       = accept && (cmd == CMD_LOAD_B) && idx_ok;
    assign rd_c       = accept && (cmd == CMD_READ_C) && idx_ok;
    assign start_exec = accept && (cmd == CMD_EXEC) && (exec_op != NONE);

    // done is only trusted once the opcode has been held long enough
    assign settled    = count_reg >= CNT_W'(SETTLE_CYCLES - 1);
    assign expired    = count_reg >= CNT_W'(TIMEOUT_CYCLES - 1);
    assign capture_go = (state_reg == ISSUE) && settled && alu.alu_done;
    assign timeout    = (state_reg == ISSUE) && expired && !capture_go;

    always_comb begin
        state_next = state_reg;
        count_next = '0;
        case (state_reg)
            IDLE: begin
                if (start_exec) state_next = ISSUE;
            end
            ISSUE: begin
                count_next = count_reg + 1'b1;
                if (capture_go)   state_next = CAPTURE;
                else if (timeout) state_next = RELEASE;
            end
            CAPTURE: state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        error_next = error_reg;
        if (accept) begin
            case (cmd)
                CMD_NOP, CMD_LOAD_F:               error_next = 1'b0;
                CMD_LOAD_A, CMD_LOAD_B, CMD_READ_C: error_next = !idx_ok;
                CMD_EXEC:                          error_next = (exec_op == NONE);
                default:                           error_next = 1'b1;
            endcase
        end else if (timeout) begin
            error_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            opcode_reg   <= NONE;
            f_reg        <= '0;
            rd_data_reg  <= '0;
            c_reg        <= '0;
            rd_valid_reg <= 1'b0;
            overflow_reg <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            error_reg    <= error_next;
            rd_valid_reg <= rd_c;
            if (rd_c)                               rd_data_reg <= c_reg[ELEM_W*int'(idx) +: ELEM_W];
            if (accept && cmd == CMD_LOAD_F)        f_reg <= data;
            if (start_exec)                         opcode_reg <= exec_op;
            if (state_reg == CAPTURE) begin
                c_reg        <= alu.alu_C_flat;
                overflow_reg <= alu.alu_overflow;
            end
        end
    end

    coproc_matrix_bank u_bank_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .wr_en   (wr_a),
        .wr_idx  (idx),
        .wr_data (data),
        .flat    (a_flat)
    );

    coproc_matrix_bank u_bank_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .wr_en   (wr_b),
        .wr_idx  (idx),
        .wr_data (data),
        .flat    (b_flat)
    );

    // Opcode drops to NONE in RELEASE so back-to-back EXECs always show an edge
    assign alu.alu_opcode = (state_reg == ISSUE || state_reg == CAPTURE) ? opcode_reg : NONE;
    assign alu.alu_A_flat = a_flat;
    assign alu.alu_B_flat = b_flat;
    assign alu.alu_f      = f_reg;

    assign instr_ready = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign op_done     = (state_reg == CAPTURE);
    assign op_overflow = overflow_reg;
    assign op_error    = error_reg;
    assign rd_valid    = rd_valid_reg;
    assign rd_data     = rd_data_reg;
endmodule

// File: tb/tb_coproc_control_unit.sv
// Randomized bench for coproc_control_unit against a timeline-based model.
module tb_coproc_control_unit;
    import coproc_pkg::*;

    localparam int SETTLE = 2;
    localparam int TMO    = 16;
    localparam int NEVER  = 1000;
    localparam int W      = FLAT_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready, rd_valid, busy, op_done, op_overflow, op_error;
    logic [7:0]  rd_data;

    coproc_if alu();

    always #5 clk = ~clk;

    coproc_control_unit #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .op_done     (op_done),
        .op_overflow (op_overflow),
        .op_error    (op_error),
        .alu         (alu)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] m_a [N_ELEM];
    logic [7:0] m_b [N_ELEM];
    logic [7:0] m_c [N_ELEM];
    logic [7:0] m_f, m_rdd;
    bit   m_ovf, m_err, m_rdv, m_tmo, check_en;
    int   idle_at, issue_from, cap_at, rel_at, t0, d_done;
    logic [2:0] m_op;

    function automatic logic [W-1:0] pack(input logic [7:0] m [N_ELEM]);
        logic [W-1:0] v = '0;
        for (int k = 0; k < N_ELEM; k++) v[8*k +: 8] = m[k];
        return v;
    endfunction

    function automatic logic [15:0] ins(input logic [2:0] c, input int fld, input int dat);
        logic [4:0] f5 = fld[4:0];
        logic [7:0] d8 = dat[7:0];
        return {d8, f5, c};
    endfunction

    function automatic logic [2:0] exp_op();
        return (cyc >= issue_from && cyc < rel_at) ? m_op : 3'b000;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_ELEM; k++) begin
            m_a[k] = '0; m_b[k] = '0; m_c[k] = '0;
        end
        m_f = '0; m_rdd = '0; m_ovf = 0; m_err = 0; m_rdv = 0; m_tmo = 0;
        idle_at = 0; issue_from = -1; cap_at = -1; rel_at = -1; t0 = -NEVER;
        m_op = 3'b000; cyc = 0; d_done = 0;
    endtask

    // Advances the model across the clock edge that ends cycle cyc.
    task automatic model_edge();
        int n = cyc;
        logic [2:0] c = instr[2:0];
        int idx = int'(instr[7:3]);
        logic [7:0] dat = instr[15:8];
        bit ok = idx < N_ELEM;
        int first;
        m_rdv = 0;
        if (n == cap_at) begin
            for (int k = 0; k < N_ELEM; k++) m_c[k] = alu.alu_C_flat[8*k +: 8];
            m_ovf = alu.alu_overflow;
        end
        if (m_tmo && n == rel_at - 1) m_err = 1;
        if (instr_valid && n >= idle_at) begin
            m_err = 0;
            case (c)
                CMD_NOP: ;
                CMD_LOAD_A: if (ok) m_a[idx] = dat; else m_err = 1;
                CMD_LOAD_B: if (ok) m_b[idx] = dat; else m_err = 1;
                CMD_LOAD_F: m_f = dat;
                CMD_READ_C: if (ok) begin m_rdv = 1; m_rdd = m_c[idx]; end else m_err = 1;
                CMD_EXEC: begin
                    if (instr[5:3] == 3'b000) begin
                        m_err = 1;
                    end else begin
                        first = n + ((d_done > SETTLE) ? d_done : SETTLE);
                        m_op = instr[5:3]; t0 = n; issue_from = n + 1;
                        if (first <= n + TMO) begin
                            m_tmo = 0; cap_at = first + 1; rel_at = first + 2; idle_at = first + 3;
                        end else begin
                            m_tmo = 1; cap_at = -1; rel_at = n + TMO + 1; idle_at = n + TMO + 2;
                        end
                    end
                end
                default: m_err = 1;
            endcase
        end
        cyc = n + 1;
    endtask

    function automatic logic done_now();
        if (cyc > t0 && cyc < rel_at) return cyc >= t0 + d_done;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        alu.alu_done = done_now();
    endtask

    task automatic drive(input logic v, input logic [15:0] word, input int dd);
        instr_valid = v;
        instr = word;
        if (v && word[2:0] == CMD_EXEC && cyc >= idle_at) d_done = dd;
    endtask

    task automatic rand_c();
        for (int k = 0; k < N_ELEM; k++) alu.alu_C_flat[8*k +: 8] = 8'($urandom);
        alu.alu_overflow = 1'($urandom);
    endtask

    task automatic sum_c(input logic ovf);
        for (int k = 0; k < N_ELEM; k++) alu.alu_C_flat[8*k +: 8] = m_a[k] + m_b[k];
        alu.alu_overflow = ovf;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("instr_ready", W'(instr_ready), W'(cyc >= idle_at));
            chk("busy", W'(busy), W'(cyc < idle_at));
            chk("alu_opcode", W'(alu.alu_opcode), W'(exp_op()));
            chk("op_done", W'(op_done), W'(cyc == cap_at));
            chk("op_error", W'(op_error), W'(m_err));
            chk("op_overflow", W'(op_overflow), W'(m_ovf));
            chk("rd_valid", W'(rd_valid), W'(m_rdv));
            if (m_rdv) chk("rd_data", W'(rd_data), W'(m_rdd));
            chk("alu_A_flat", alu.alu_A_flat, pack(m_a));
            chk("alu_B_flat", alu.alu_B_flat, pack(m_b));
            chk("alu_f", W'(alu.alu_f), W'(m_f));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int r, fld;
        logic [2:0] c;
        alu.alu_done = 1'b0; alu.alu_overflow = 1'b0; alu.alu_C_flat = '0;
        model_reset();
        check_en = 0;

        // Asynchronous reset asserted between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_opcode", W'(alu.alu_opcode), W'(0));
        chk("rst_op_done", W'(op_done), W'(0));
        chk("rst_rd_valid", W'(rd_valid), W'(0));
        chk("rst_rd_data", W'(rd_data), W'(0));
        chk("rst_op_error", W'(op_error), W'(0));
        chk("rst_op_overflow", W'(op_overflow), W'(0));
        chk("rst_a_flat", alu.alu_A_flat, W'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        #1;
        chk("rst_ready", W'(instr_ready), W'(1));
        check_en = 1;

        // Sum path with pinned latencies
        drive(1, ins(CMD_LOAD_A, 0, 3), 0); tick();
        drive(1, ins(CMD_LOAD_B, 0, 4), 0); tick();
        sum_c(1'b0);
        drive(1, ins(CMD_EXEC, int'(SUM), 0), 0);
        tick(); drive(0, 16'h0, 0);
        chk("lit_opcode_c1", W'(alu.alu_opcode), W'(3'b001));
        chk("lit_ready_c1", W'(instr_ready), W'(0));
        tick(); tick();
        chk("lit_op_done_c3", W'(op_done), W'(1));
        tick();
        chk("lit_opcode_c4", W'(alu.alu_opcode), W'(0));
        chk("lit_busy_c4", W'(busy), W'(1));
        tick();
        chk("lit_ready_c5", W'(instr_ready), W'(1));
        drive(1, ins(CMD_READ_C, 0, 0), 0); tick(); drive(0, 16'h0, 0);
        chk("lit_rd_valid", W'(rd_valid), W'(1));
        chk("lit_rd_data", W'(rd_data), W'(7));

        // Bad index, clearing NOP, EXEC with no opcode
        drive(1, ins(CMD_LOAD_A, 25, 8'h99), 0); tick(); drive(0, 16'h0, 0);
        chk("lit_badidx_err", W'(op_error), W'(1));
        chk("lit_badidx_a", alu.alu_A_flat, W'(3));
        drive(1, ins(CMD_NOP, 0, 0), 0); tick(); drive(0, 16'h0, 0);
        chk("lit_nop_clears", W'(op_error), W'(0));
        drive(1, ins(CMD_EXEC, 0, 0), 0); tick(); drive(0, 16'h0, 0);
        chk("lit_exec0_err", W'(op_error), W'(1));
        chk("lit_exec0_busy", W'(busy), W'(0));

        // Timeout with a load attempted while busy
        drive(1, ins(CMD_EXEC, int'(DET), 0), NEVER); rand_c(); tick();
        chk("lit_tmo_opcode", W'(alu.alu_opcode), W'(3'b111));
        drive(1, ins(CMD_LOAD_A, 1, 8'h55), 0);
        for (int i = 0; i < TMO - 1; i++) begin rand_c(); tick(); end
        chk("lit_tmo_last_issue", W'(alu.alu_opcode), W'(3'b111));
        chk("lit_tmo_ignored", W'(instr_ready), W'(0));
        rand_c(); tick();
        chk("lit_tmo_release_op", W'(alu.alu_opcode), W'(0));
        chk("lit_tmo_err", W'(op_error), W'(1));
        tick(); drive(1, ins(CMD_READ_C, 0, 0), 0);
        chk("lit_tmo_ready", W'(instr_ready), W'(1));
        tick(); drive(0, 16'h0, 0);
        chk("lit_tmo_c_kept", W'(rd_data), W'(7));
        chk("lit_tmo_a_kept", alu.alu_A_flat, W'(3));

        // Overflow capture and hold
        sum_c(1'b1);
        drive(1, ins(CMD_EXEC, int'(MUL), 0), 0); tick(); drive(0, 16'h0, 0);
        repeat (4) tick();
        chk("lit_ovf_set", W'(op_overflow), W'(1));
        drive(1, ins(CMD_READ_C, 0, 0), 0); tick(); drive(0, 16'h0, 0);
        chk("lit_ovf_held", W'(op_overflow), W'(1));
        sum_c(1'b0);
        drive(1, ins(CMD_EXEC, int'(SUM), 0), 0); tick(); drive(0, 16'h0, 0);
        repeat (4) tick();
        chk("lit_ovf_clear", W'(op_overflow), W'(0));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_c();
            r = $urandom_range(0, 9);
            if (r < 2)      c = CMD_LOAD_A;
            else if (r < 4) c = CMD_LOAD_B;
            else if (r < 5) c = CMD_LOAD_F;
            else if (r < 7) c = CMD_EXEC;
            else if (r < 9) c = CMD_READ_C;
            else            c = 3'($urandom_range(0, 7));
            fld = ($urandom_range(0, 7) == 0) ? $urandom_range(25, 31) : $urandom_range(0, 24);
            drive(1'($urandom_range(0, 3) != 0), ins(c, fld, $urandom_range(0, 255)),
                  ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, 18));
            tick();
        end
        drive(0, 16'h0, 0);
        for (int i = 0; i < 40 && cyc < idle_at; i++) tick();
        chk("drain_ready", W'(instr_ready), W'(1));

        // Reset in the middle of ISSUE
        drive(1, ins(CMD_EXEC, int'(TRN), 0), NEVER); tick(); drive(0, 16'h0, 0); tick();
        chk("lit_mid_busy", W'(busy), W'(1));
        chk("lit_mid_opcode", W'(alu.alu_opcode), W'(3'b101));
        check_en = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", W'(busy), W'(0));
        chk("mid_rst_opcode", W'(alu.alu_opcode), W'(0));
        chk("mid_rst_a", alu.alu_A_flat, W'(0));
        chk("mid_rst_b", alu.alu_B_flat, W'(0));
        chk("mid_rst_err", W'(op_error), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_en = 1;
        repeat (5) tick();
        chk("post_rst_ready", W'(instr_ready), W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
